// File: rtl/gray_ptr_decode_if.sv
// Handshake bundle for the Gray pointer decoder: Gray words in, binary/delta/error out.
interface gray_ptr_decode_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_gray;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_bin;
  logic [DW-1:0] out_delta;
  logic          out_err;

  // Decoder side.
  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, out_delta, out_err
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, out_delta, out_err
  );
endinterface

// File: rtl/gray_ptr_decode.sv
// Two-stage Gray-to-binary decoder for synchronized pointers: reports binary value,
// modular step since the previous word, and a multi-bit-change error flag.
module gray_ptr_decode #(
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  gray_ptr_decode_if.slave   bus,
  input  logic               err_clear,
  output logic               err_sticky
);

  logic          r_s1_valid;
  logic [DW-1:0] r_s1_gray;
  logic          r_out_valid;
  logic [DW-1:0] r_out_bin;
  logic [DW-1:0] r_out_delta;
  logic          r_out_err;
  logic [DW-1:0] r_prev_gray;
  logic [DW-1:0] r_prev_bin;
  logic          r_first;
  logic          r_err_sticky;

  logic          w_adv;
  logic          w_load;
  logic [DW-1:0] w_bin;
  logic [DW-1:0] w_x;
  logic          w_multi;
  logic [DW-1:0] w_delta;
  logic          w_err;

  assign w_adv  = !r_out_valid || bus.out_ready;
  assign w_load = w_adv && r_s1_valid;

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_decode
      assign w_bin[gi] = ^r_s1_gray[DW-1:gi];
    end
  endgenerate

  // More than one set bit in the change mask means the single-bit rule broke.
  assign w_x     = r_s1_gray ^ r_prev_gray;
  assign w_multi = |(w_x & (w_x - DW'(1)));
  assign w_delta = r_first ? '0 : (w_bin - r_prev_bin);
  assign w_err   = !r_first && w_multi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_gray    <= '0;
      r_out_valid  <= 1'b0;
      r_out_bin    <= '0;
      r_out_delta  <= '0;
      r_out_err    <= 1'b0;
      r_prev_gray  <= '0;
      r_prev_bin   <= '0;
      r_first      <= 1'b1;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_valid  <= bus.in_valid;
        r_s1_gray   <= bus.in_gray;
        r_out_valid <= r_s1_valid;
      end
      if (w_load) begin
        r_out_bin   <= w_bin;
        r_out_delta <= w_delta;
        r_out_err   <= w_err;
        r_prev_gray <= r_s1_gray;
        r_prev_bin  <= w_bin;
        r_first     <= 1'b0;
      end
      // A new error outranks a simultaneous clear.
      if (w_load && w_err) begin
        r_err_sticky <= 1'b1;
      end else if (err_clear) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_adv && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_delta = r_out_delta;
  assign bus.out_err   = r_out_err;
  assign err_sticky    = r_err_sticky;

endmodule

// File: doc/gray_ptr_decode.md
# gray_ptr_decode

Pipelined Gray-to-binary decoder with a valid/ready handshake. It is the receive-side counterpart of the binary-to-Gray encoder used on pointer and counter crossings. It takes Gray-coded words that have already been synchronized into the local clock domain. For each word it produces:
- the binary value,
- the modular step since the previous word,
- a flag when the Gray single-bit-change rule is violated.

It sits after the pointer synchronizer in async FIFOs and counter-crossing paths.

## Interface

Parameters:
- DW, 32, width of the Gray input and binary output (DW >= 2)

Ports:
- clk  input  1  single clock; all logic is rising-edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_gray holds a word this cycle
- in_ready  output  1  block accepts the word this cycle
- in_gray  input  DW  Gray-encoded input word
- out_valid  output  1  output word is valid
- out_ready  input  1  downstream accepts the output this cycle
- out_bin  output  DW  decoded binary value
- out_delta  output  DW  (out_bin − previous out_bin) mod 2^DW
- out_err  output  1  this word differs from the previous accepted Gray word in more than 1 bit
- err_sticky  output  1  latched OR of out_err since reset or clear
- err_clear  input  1  clears err_sticky

## Operation

- Two register stages, S1 and S2, advance together under one enable: adv = !out_valid || out_ready.
- in_ready = adv && !reset. Transfer happens when in_valid && in_ready.
- S1 on adv: s1_valid <= in_valid; s1_gray <= in_gray.
- S2 on adv: out_valid <= s1_valid. When s1_valid, S2 loads the decoded results.
- Decode: bin[DW−1] = g[DW−1]; bin[i] = bin[i+1] ^ g[i] for i = DW−2 down to 0.
- History registers prev_gray, prev_bin and first (first = 1 after reset). They update only when S2 loads a valid word: prev_* <= the new values, first <= 0.
- out_delta = bin − prev_bin, truncated to DW bits, so wrap-around is natural. out_delta = 0 when first = 1.
- Error check: x = s1_gray ^ prev_gray; out_err = (x & (x − 1)) != 0.
  - out_err is forced to 0 when first = 1.
  - x = 0 (repeated word) is legal: delta = 0, no error.
- err_sticky: set when S2 loads a word with out_err = 1; cleared by err_clear. If both happen in the same cycle, set wins.
- Stall (out_valid && !out_ready): S1, S2, history and all outputs hold. in_ready = 0, so no input is lost or duplicated.
- out_bin, out_delta and out_err hold their last loaded values while out_valid = 0. Downstream must ignore them.

## Timing

- Latency: a word accepted in cycle N appears with out_valid = 1 in cycle N+2 when there are no stalls.
- Throughput: 1 word per cycle when out_ready is held high.
- in_ready is combinational from out_valid, out_ready and reset. There is no combinational path from in_valid or in_gray to any output.
- Reset (synchronous, on any cycle, including mid-stream):
  - next cycle: out_valid = 0, s1_valid = 0, out_bin = 0, out_delta = 0, out_err = 0, err_sticky = 0, prev_gray = 0, prev_bin = 0, first = 1;
  - in_ready = 0 while reset is high;
  - in-flight words are discarded.
- The first word after reset is never flagged and reports delta 0.

## Test plan

- Sequence (DW=4, out_ready=1): in_gray 0000, 0001, 0011, 0010, 0110 on consecutive cycles -> starting 2 cycles later, out_bin 0, 1, 2, 3, 4; out_delta 0, 1, 1, 1, 1; out_err always 0.
- Wrap (DW=4): in_gray 1000 (bin 15) then 0000 -> out_bin 15 then 0; second out_delta = 1; out_err = 0.
- Error (DW=4): in_gray 0000 then 0011 -> second word out_bin 2, out_delta 2, out_err = 1, err_sticky = 1 until err_clear. Then pulse err_clear in the same cycle as another 2-bit jump (0011 -> 0000) -> err_sticky stays 1.
- Backpressure: stream 0001, 0011, 0010, 0110 with out_ready low for 3 cycles once the first output is valid -> in_ready = 0 and outputs frozen during the stall. After release, all four words arrive in order with none dropped or duplicated.
- Mid-stream reset: assert reset for 1 cycle while two words are in flight -> out_valid = 0 next cycle. The following input 0110 gives out_bin 4, out_delta 0, out_err 0 (first rule applies).
- Repeat and width (DW=32): in_gray 0xC0000000 twice -> out_bin 0x80000000 both times; second word out_delta 0, out_err 0.
